// File: rtl/lbm_init_seq.sv
// lbm_init_seq -- writes the initial lattice-Boltzmann state for a square grid.
// For every cell it writes density/velocity once (MACRO step) and then the nine
// equilibrium distribution values (DIST steps, dir 0..8), cell by cell, with
// count_init_en acting as a stall from the memory controller.
// Optional feature: define LBM_LID_INIT_EN to preload the top grid row with the
// lid velocity on ux.
//
// Handshake: a step is taken only on a rising Clk where count_init_en=1 while
// busy=1; the write for that step appears on the registered outputs on the
// following cycle. With count_init_en=0 nothing advances and no WE is asserted.
module lbm_init_seq #(
    parameter int                    GRID_DIM   = 256,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ROW_LEN    = 16,
    parameter logic [DATA_WIDTH-1:0] W0         = 32'h0000_71C7,
    parameter logic [DATA_WIDTH-1:0] W1         = 32'h0000_1C72,
    parameter logic [DATA_WIDTH-1:0] W5         = 32'h0000_071C,
    parameter logic [DATA_WIDTH-1:0] RHO0       = 32'h0001_0000,
    parameter logic [DATA_WIDTH-1:0] U_LID      = 32'h0000_0CCD
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  count_init_en,
    output logic [7:0]            count_init,
    output logic [7:0]            cell_addr,
    output logic [11:0]           fin_addr,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic [DATA_WIDTH-1:0] ux_data,
    output logic [DATA_WIDTH-1:0] uy_data,
    output logic [DATA_WIDTH-1:0] fin_data,
    output logic                  WE_p_mem,
    output logic                  WE_ux_mem,
    output logic                  WE_uy_mem,
    output logic                  WE_fin_mem,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MACRO = 2'd1,
        S_DIST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CELL = 8'(GRID_DIM - 1);
    localparam logic [7:0] LID_FIRST = 8'(GRID_DIM - ROW_LEN);
    localparam logic [3:0] LAST_DIR  = 4'd8;

`ifdef LBM_LID_INIT_EN
    localparam logic LID_EN = 1'b1;
`else
    localparam logic LID_EN = 1'b0;
`endif

    state_t                r_state;
    state_t                w_next_state;
    logic [7:0]            r_cell;
    logic [7:0]            w_next_cell;
    logic [3:0]            r_dir;
    logic [3:0]            w_next_dir;
    logic                  w_we_macro;
    logic                  w_we_fin;
    logic [11:0]           w_fin_addr;
    logic [DATA_WIDTH-1:0] w_fin_data;
    logic [DATA_WIDTH-1:0] w_ux_val;

    logic [7:0]            r_cell_addr;
    logic [11:0]           r_fin_addr;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic [DATA_WIDTH-1:0] r_ux_data;
    logic [DATA_WIDTH-1:0] r_uy_data;
    logic [DATA_WIDTH-1:0] r_fin_data;
    logic                  r_we_p;
    logic                  r_we_ux;
    logic                  r_we_uy;
    logic                  r_we_fin;
    logic                  r_busy;
    logic                  r_done;

    // cell*9 built as cell*8+cell; max 255*9+8 = 2303 fits in 12 bits.
    assign w_fin_addr = ({4'd0, r_cell} << 3) + {4'd0, r_cell} + {8'd0, r_dir};

    // Top-row cells get the lid velocity only when the lid feature is built in.
    assign w_ux_val = (LID_EN && (r_cell >= LID_FIRST)) ? U_LID : '0;

    // Equilibrium weight for the current direction group.
    always_comb begin
        w_fin_data = W5;
        if (r_dir == 4'd0) begin
            w_fin_data = W0;
        end else if (r_dir <= 4'd4) begin
            w_fin_data = W1;
        end
    end

    // FSM state, cell and direction registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cell  <= 8'd0;
            r_dir   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cell  <= w_next_cell;
            r_dir   <= w_next_dir;
        end
    end

    // Next-state logic and write strobes for the current step.
    always_comb begin
        w_next_state = r_state;
        w_next_cell  = r_cell;
        w_next_dir   = r_dir;
        w_we_macro   = 1'b0;
        w_we_fin     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next_state = S_MACRO;
                    w_next_cell  = 8'd0;
                    w_next_dir   = 4'd0;
                end
            end
            S_MACRO: begin
                if (count_init_en) begin
                    w_we_macro   = 1'b1;
                    w_next_state = S_DIST;
                    w_next_dir   = 4'd0;
                end
            end
            S_DIST: begin
                if (count_init_en) begin
                    w_we_fin = 1'b1;
                    if (r_dir == LAST_DIR) begin
                        // Last cell finishes the grid instead of wrapping.
                        if (r_cell == LAST_CELL) begin
                            w_next_state = S_DONE;
                        end else begin
                            w_next_cell  = r_cell + 8'd1;
                            w_next_dir   = 4'd0;
                            w_next_state = S_MACRO;
                        end
                    end else begin
                        w_next_dir = r_dir + 4'd1;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Registered outputs: writes land one cycle after the enabled step.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cell_addr <= 8'd0;
            r_fin_addr  <= 12'd0;
            r_p_data    <= '0;
            r_ux_data   <= '0;
            r_uy_data   <= '0;
            r_fin_data  <= '0;
            r_we_p      <= 1'b0;
            r_we_ux     <= 1'b0;
            r_we_uy     <= 1'b0;
            r_we_fin    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cell_addr <= r_cell;
            r_we_p      <= w_we_macro;
            r_we_ux     <= w_we_macro;
            r_we_uy     <= w_we_macro;
            r_we_fin    <= w_we_fin;
            r_busy      <= (w_next_state == S_MACRO) || (w_next_state == S_DIST);
            r_done      <= (w_next_state == S_DONE);
            if (w_we_macro) begin
                r_p_data  <= RHO0;
                r_ux_data <= w_ux_val;
                r_uy_data <= '0;
            end
            if (w_we_fin) begin
                r_fin_addr <= w_fin_addr;
                r_fin_data <= w_fin_data;
            end
        end
    end

    assign count_init  = r_cell_addr;
    assign cell_addr   = r_cell_addr;
    assign fin_addr    = r_fin_addr;
    assign p_data      = r_p_data;
    assign ux_data     = r_ux_data;
    assign uy_data     = r_uy_data;
    assign fin_data    = r_fin_data;
    assign WE_p_mem    = r_we_p;
    assign WE_ux_mem   = r_we_ux;
    assign WE_uy_mem   = r_we_uy;
    assign WE_fin_mem  = r_we_fin;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lbm_init_seq.sv
// Bench for lbm_init_seq: reference write list per grid pass, checked by a
// negedge monitor against the DUT write strobes.
module tb_lbm_init_seq;

  localparam int PW = 104;  // {cell 8, p 32, ux 32, uy 32}
  localparam int FW = 44;   // {fin_addr 12, fin_data 32}
  localparam logic [31:0] M_W0 = 32'h0000_71C7;
  localparam logic [31:0] M_W1 = 32'h0000_1C72;
  localparam logic [31:0] M_W5 = 32'h0000_071C;
  localparam logic [31:0] M_RHO = 32'h0001_0000;
  localparam logic [31:0] M_ULID = 32'h0000_0CCD;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] count_init, cell_addr;
  logic [11:0] fin_addr;
  logic [31:0] p_data, ux_data, uy_data, fin_data;
  logic we_p, we_ux, we_uy, we_fin, busy, done;
  logic [1:0] dbg_state;

  lbm_init_seq dut (
    .Clk(clk), .Reset(rst), .start(start), .count_init_en(en),
    .count_init(count_init), .cell_addr(cell_addr), .fin_addr(fin_addr),
    .p_data(p_data), .ux_data(ux_data), .uy_data(uy_data), .fin_data(fin_data),
    .WE_p_mem(we_p), .WE_ux_mem(we_ux), .WE_uy_mem(we_uy), .WE_fin_mem(we_fin),
    .busy(busy), .done(done), .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail = 0;
  logic [PW-1:0] p_q[$];
  logic [FW-1:0] fin_q[$];
  int n_p = 0;
  int n_fin = 0;
  int cyc = 0;
  int t_busy = 0;
  int t_done = 0;
  logic en_at_edge = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  logic chk_after_stall = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: the full ordered write list for one grid pass
  function automatic logic [31:0] weight(input int d);
    if (d == 0) return M_W0;
    if (d <= 4) return M_W1;
    return M_W5;
  endfunction

  function automatic logic [31:0] lid_ux(input int c);
`ifdef LBM_LID_INIT_EN
    if (c >= 256 - 16) return M_ULID;
`endif
    return 32'd0;
  endfunction

  task automatic push_grid();
    for (int c = 0; c < 256; c++) begin
      p_q.push_back({8'(c), M_RHO, lid_ux(c), 32'd0});
      for (int d = 0; d < 9; d++) begin
        fin_q.push_back({12'(c * 9 + d), weight(d)});
      end
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_seq();
    push_grid();
    n_p = 0;
    n_fin = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i >= budget) chk("done_timeout", 0, 1);
    tick(1);
  endtask

  task automatic end_of_run(input string name, input bit chk_len, input int len);
    chk({name, "_done"}, done, 1);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_count_init_last"}, count_init, 8'd255);
    chk({name, "_n_p"}, n_p, 256);
    chk({name, "_n_fin"}, n_fin, 2304);
    chk({name, "_p_q_empty"}, p_q.size(), 0);
    chk({name, "_fin_q_empty"}, fin_q.size(), 0);
    if (chk_len) chk({name, "_cycles"}, t_done - t_busy, len);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_we"}, {we_p, we_ux, we_uy, we_fin}, 4'd0);
    chk({name, "_flags"}, {busy, done}, 2'd0);
    chk({name, "_addr"}, {count_init, cell_addr, fin_addr}, 28'd0);
    chk({name, "_data"}, {p_data, ux_data, uy_data, fin_data}, 128'd0);
  endtask

  // monitor: edge bookkeeping
  always @(posedge clk) begin
    cyc++;
    en_at_edge = en;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [PW-1:0] pe;
    logic [FW-1:0] fe;
    if (busy && !prev_busy) t_busy = cyc;
    if (done && !prev_done) t_done = cyc;
    prev_busy = busy;
    prev_done = done;
    if (!en_at_edge) chk("stall_no_we", {we_p, we_ux, we_uy, we_fin}, 4'd0);
    if (we_p || we_ux || we_uy) begin
      n_p++;
      chk("macro_we_together", {we_p, we_ux, we_uy}, 3'b111);
      if (p_q.size() == 0) begin
        chk("p_unexpected", 1, 0);
      end else begin
        pe = p_q.pop_front();
        chk("p_write", {cell_addr, p_data, ux_data, uy_data}, pe);
        chk("count_init", count_init, pe[PW-1 -: 8]);
      end
    end
    if (we_fin) begin
      n_fin++;
      if (chk_after_stall) begin
        chk("fin_addr_after_stall", fin_addr, 12'd31);
        chk_after_stall = 1'b0;
      end
      if (fin_q.size() == 0) begin
        chk("fin_unexpected", 1, 0);
      end else begin
        fe = fin_q.pop_front();
        chk("fin_write", {fin_addr, fin_data}, fe);
      end
    end
  end

  // stimulus
  initial begin
    // reset for two cycles, then idle
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_idle");
    tick(3);
    chk_all_zero("idle_after_reset");

    // full pass with enable held high
    en = 1'b1;
    start_seq();
    wait_done(3000);
    end_of_run("full", 1'b1, 2560);
    tick(4);
    chk("done_held", done, 1);

    // stall for 5 cycles at cell 3 dir 4 (enabled step 35)
    start_seq();
    tick(35);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    chk_after_stall = 1'b1;
    wait_done(3000);
    end_of_run("stall", 1'b1, 2565);
    chk("stall_addr_seen", chk_after_stall, 0);

    // reset at cell 100, with start asserted in the same cycle
    start_seq();
    tick(1003);
    rst = 1'b1;
    start = 1'b1;
    tick(1);
    p_q.delete();
    fin_q.delete();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    tick(3);
    chk_all_zero("mid_reset_idle");
    start_seq();
    wait_done(3000);
    end_of_run("restart", 1'b1, 2560);

    // start re-pulsed while busy at cell 50 is ignored
    start_seq();
    tick(503);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_at_cell50", busy, 1);
    chk("not_done_at_cell50", done, 0);
    wait_done(3000);
    end_of_run("repulse", 1'b1, 2560);

    // random stalls
    start_seq();
    for (int i = 0; i < 9000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      tick(1);
      if (done) break;
    end
    en = 1'b1;
    tick(2);
    end_of_run("random", 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lbm_init_seq.md
LBM_INIT_SEQ -- requirements
Module: lbm_init_seq

Interface
REQ-001 The block SHALL have parameter GRID_DIM, default 256, number of lattice cells (16x16 grid).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, Q16.16 word width of all written values.
REQ-003 The block SHALL have parameter ROW_LEN, default 16, cells per grid row.
REQ-004 The block SHALL have parameters W0 = 32'h0000_71C7, W1 = 32'h0000_1C72 and W5 = 32'h0000_071C: rest weights times rho0, for directions 0, 1-4 and 5-8.
REQ-005 The block SHALL have parameters RHO0 = 32'h0001_0000, initial density, and U_LID = 32'h0000_0CCD, lid velocity.
REQ-006 The block SHALL have port Clk, input, 1 bit: single clock, rising edge.
REQ-007 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: begin initialisation (sampled only in IDLE).
REQ-009 The block SHALL have port count_init_en, input, 1 bit: advance enable from controller; low = stall.
REQ-010 The block SHALL have port count_init, output, 8 bits: current cell index to controller.
REQ-011 The block SHALL have port cell_addr, output, 8 bits: address for p/ux/uy memories.
REQ-012 The block SHALL have port fin_addr, output, 12 bits: fin memory address, cell*9+dir.
REQ-013 The block SHALL have ports p_data, ux_data, uy_data and fin_data, output, DATA_WIDTH each: write data.
REQ-014 The block SHALL have ports WE_p_mem, WE_ux_mem, WE_uy_mem and WE_fin_mem, output, 1 bit each: write enables.
REQ-015 The block SHALL have port busy, output, 1 bit: sequence in progress.
REQ-016 The block SHALL have port done, output, 1 bit: all cells written; held until the next accepted start.

Function
REQ-017 The FSM SHALL have the states IDLE, MACRO, DIST and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL load cell=0 and dir=0, clear done and enter MACRO next cycle.
REQ-019 In MACRO with count_init_en=1, the block SHALL assert WE_p_mem, WE_ux_mem and WE_uy_mem for one cycle, with cell_addr=cell, p_data=RHO0, ux_data=0 and uy_data=0, then enter DIST with dir=0.
REQ-020 In DIST with count_init_en=1, the block SHALL assert WE_fin_mem with fin_addr=cell*9+dir and fin_data=W0/W1/W5 per dir group; dir SHALL then increment.
REQ-021 At dir=8 in DIST: if cell=GRID_DIM-1, the FSM SHALL enter DONE; otherwise cell SHALL increment, dir SHALL clear and the FSM SHALL enter MACRO.
REQ-022 Each cell SHALL take exactly 10 enabled cycles; a full grid with count_init_en held high SHALL take 2560 cycles from the first MACRO cycle to DONE entry.
REQ-023 count_init_en=0 in MACRO or DIST SHALL hold state, cell and dir, and SHALL drive all WE low; no write is lost or duplicated.
REQ-024 All outputs SHALL be registered; each write SHALL appear on the cycle after the enabled FSM cycle.
REQ-025 count_init SHALL equal cell, driven from the same register stage as cell_addr.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 busy SHALL be 1 exactly in MACRO and DIST.
REQ-028 fin_addr SHALL be computed as cell*8+cell+dir in 12 bits; its maximum value is 2303 and it SHALL never wrap.
REQ-029 cell SHALL not wrap past GRID_DIM-1; the DONE transition takes priority over the increment.

Reset
REQ-030 Reset=1 on a rising Clk SHALL force IDLE, cell=0 and dir=0, and drive all outputs to 0 (WE, busy, done, addresses and data), regardless of state.
REQ-031 Reset mid-sequence SHALL abandon the sequence; a new start SHALL be required, and the grid restarts at cell 0.
REQ-032 Reset SHALL take priority over start and count_init_en in the same cycle.

Configuration
REQ-033 The block SHALL support compile macro LBM_LID_INIT_EN.
REQ-034 With LBM_LID_INIT_EN defined, MACRO writes for cells >= GRID_DIM-ROW_LEN (top row, 240..255) SHALL use ux_data=U_LID; all other values SHALL be unchanged.
REQ-035 Without LBM_LID_INIT_EN, ux_data SHALL be 0 for every cell.

Verification
REQ-036 The bench SHALL cover: Reset for 2 cycles, then idle -> all outputs 0, busy=0, done=0.
REQ-037 The bench SHALL cover: start pulse, count_init_en held 1 -> cell 0 writes p=0x00010000, fin_addr 0..8 with data 0x71C7, 0x1C72 x4, 0x071C x4; count_init reaches 255; done=1 after 2560 cycles.
REQ-038 The bench SHALL cover: count_init_en=0 for 5 cycles during cell 3, dir 4 -> no WE in those cycles; next fin write is addr 31; total write count 256 p plus 2304 fin.
REQ-039 The bench SHALL cover: Reset asserted at cell 100 -> the next cycle is IDLE with outputs 0; start -> writes resume from cell_addr 0.
REQ-040 The bench SHALL cover: start re-pulsed while busy at cell 50 -> ignored; sequence unchanged; done only after cell 255.
REQ-041 The bench SHALL cover: with LBM_LID_INIT_EN, cell 239 -> ux=0 and cell 240 -> ux=0x00000CCD; without the macro, cell 240 -> ux=0.
